// File: rtl/ddr_rpath_if.sv
// Capture-side strobe/data and read-side FWFT handshake of the DDR read path.
interface ddr_rpath_if #(
  parameter int DQ_WIDTH = 16
);
  logic                  sample;
  logic [DQ_WIDTH-1:0]   cap_d0;
  logic [DQ_WIDTH-1:0]   cap_d1;
  logic [2*DQ_WIDTH-1:0] rdata_dout;
  logic                  rdata_last;
  logic                  rdata_valid;
  logic                  rdata_ready;

  modport master (
    output sample, cap_d0, cap_d1, rdata_ready,
    input  rdata_dout, rdata_last, rdata_valid
  );

  modport slave (
    input  sample, cap_d0, cap_d1, rdata_ready,
    output rdata_dout, rdata_last, rdata_valid
  );
endinterface

// File: rtl/ddr_rpath.sv
// DDR read path: packs captured DQ pairs into words, tags BL4 burst ends and
// buffers them in a first-word-fall-through FIFO with sticky error flags.
module ddr_rpath #(
  parameter int DQ_WIDTH   = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clr,
  ddr_rpath_if.slave          bus,
  output logic [ADDR_WIDTH:0] level,
  output logic                overflow,
  output logic                burst_err
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int WW    = 2 * DQ_WIDTH + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BEAT1 = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;
  logic                  burst_err_q, burst_err_d;
  logic                  valid_q, valid_d;
  logic [WW-1:0]         mem_q [DEPTH];

  logic                  push_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  push_ok_s;
  logic                  drop_s;
  logic                  tag_last_s;
  logic [WW-1:0]         head_s;

  assign full_s     = (level_q == (ADDR_WIDTH+1)'(DEPTH));
  assign push_s     = bus.sample & ~clr;
  assign pop_s      = valid_q & bus.rdata_ready & ~clr;
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign push_ok_s  = push_s & (~full_s | pop_s);
  assign drop_s     = push_s & full_s & ~pop_s;
  assign tag_last_s = (state_q == ST_BEAT1);

  // Next-state computation for burst tracking, pointers, level and flags.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    burst_err_d = burst_err_q;
    if (clr) begin
      state_d     = ST_IDLE;
      level_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      burst_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.sample) begin
            state_d = ST_BEAT1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BEAT1: begin
          state_d = ST_IDLE;
          if (bus.sample) begin
            burst_err_d = burst_err_q;
          end else begin
            burst_err_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      level_d = level_q + (ADDR_WIDTH+1)'(push_ok_s) - (ADDR_WIDTH+1)'(pop_s);
      if (drop_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
    valid_d = (level_d != '0);
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      level_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      burst_err_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      burst_err_q <= burst_err_d;
      valid_q     <= valid_d;
    end
  end

  // Storage array; contents are only meaningful below the level count.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= {tag_last_s, bus.cap_d1, bus.cap_d0};
    end
  end

  assign head_s          = mem_q[rd_ptr_q];
  assign bus.rdata_dout  = head_s[2*DQ_WIDTH-1:0];
  assign bus.rdata_last  = head_s[WW-1];
  assign bus.rdata_valid = valid_q;
  assign level           = level_q;
  assign overflow        = overflow_q;
  assign burst_err       = burst_err_q;
endmodule

// File: tb/tb_ddr_rpath.sv
// Directed self-checking bench for ddr_rpath (DQ_WIDTH=16, depth 8).
module tb_ddr_rpath;
  logic       clk;
  logic       reset_n;
  logic       clr;
  logic [3:0] level;
  logic       overflow;
  logic       burst_err;
  int         checks;
  int         failures;

  ddr_rpath_if #(.DQ_WIDTH(16)) bus ();

  ddr_rpath #(.DQ_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .bus       (bus),
    .level     (level),
    .overflow  (overflow),
    .burst_err (burst_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [15:0] d1, input logic [15:0] d0);
    bus.sample = s;
    bus.cap_d1 = d1;
    bus.cap_d0 = d0;
  endtask

  initial begin
    logic [31:0] exp_w;
    logic        exp_l;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    clr      = 1'b0;
    bus.rdata_ready = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000);
    step();
    step();
    check("rst_level", 64'(level), 64'd0);
    check("rst_valid", 64'(bus.rdata_valid), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_berr", 64'(burst_err), 64'd0);
    reset_n = 1'b1;
    step();

    // Single burst, latency and FWFT head
    drive(1'b1, 16'hAAAA, 16'h5555);
    step();
    check("lat_valid", 64'(bus.rdata_valid), 64'd1);
    check("lat_level", 64'(level), 64'd1);
    drive(1'b1, 16'h1234, 16'h5678);
    step();
    drive(1'b0, 16'h0000, 16'h0000);
    step();
    check("b1_level", 64'(level), 64'd2);
    check("b1_head0", 64'(bus.rdata_dout), 64'hAAAA5555);
    check("b1_last0", 64'(bus.rdata_last), 64'd0);
    check("b1_berr", 64'(burst_err), 64'd0);
    bus.rdata_ready = 1'b1;
    step();
    check("b1_head1", 64'(bus.rdata_dout), 64'h12345678);
    check("b1_last1", 64'(bus.rdata_last), 64'd1);
    check("b1_level1", 64'(level), 64'd1);
    step();
    check("b1_empty_valid", 64'(bus.rdata_valid), 64'd0);
    step();
    check("empty_pop_level", 64'(level), 64'd0);
    bus.rdata_ready = 1'b0;

    // Fill to full with 4 bursts
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'h1000 + 16'(i), 16'h2000 + 16'(i));
      step();
    end
    drive(1'b0, 16'h0000, 16'h0000);
    step();
    check("full_level", 64'(level), 64'd8);
    check("full_ovf", 64'(overflow), 64'd0);

    // Full with simultaneous push and pop
    bus.rdata_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      drive(1'b1, 16'h3000 + 16'(j), 16'h4000 + 16'(j));
      step();
      check("trf_level", 64'(level), 64'd8);
    end
    bus.rdata_ready = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000);
    step();
    check("trf_ovf", 64'(overflow), 64'd0);
    check("trf_head", 64'(bus.rdata_dout), 64'h10022002);

    // Fifth burst dropped while full
    drive(1'b1, 16'hDEAD, 16'hBEEF);
    step();
    step();
    drive(1'b0, 16'h0000, 16'h0000);
    step();
    check("drop_level", 64'(level), 64'd8);
    check("drop_ovf", 64'(overflow), 64'd1);
    check("drop_berr", 64'(burst_err), 64'd0);

    // Drain and verify order and tags
    bus.rdata_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        exp_w = {16'h1000 + 16'(k + 2), 16'h2000 + 16'(k + 2)};
        exp_l = 1'(k % 2);
      end else begin
        exp_w = {16'h3000 + 16'(k - 6), 16'h4000 + 16'(k - 6)};
        exp_l = 1'(k - 6);
      end
      check("drain_data", 64'(bus.rdata_dout), 64'(exp_w));
      check("drain_last", 64'(bus.rdata_last), 64'(exp_l));
      step();
    end
    bus.rdata_ready = 1'b0;
    check("drain_level", 64'(level), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_ovf", 64'(overflow), 64'd0);

    // Short burst then a proper burst
    drive(1'b1, 16'h0101, 16'h0202);
    step();
    drive(1'b0, 16'h0000, 16'h0000);
    step();
    check("short_berr", 64'(burst_err), 64'd1);
    check("short_level", 64'(level), 64'd1);
    check("short_last", 64'(bus.rdata_last), 64'd0);
    drive(1'b1, 16'h0303, 16'h0404);
    step();
    drive(1'b1, 16'h0505, 16'h0606);
    step();
    drive(1'b0, 16'h0000, 16'h0000);
    bus.rdata_ready = 1'b1;
    step();
    check("nb_head0", 64'(bus.rdata_dout), 64'h03030404);
    check("nb_last0", 64'(bus.rdata_last), 64'd0);
    step();
    check("nb_head1", 64'(bus.rdata_dout), 64'h05050606);
    check("nb_last1", 64'(bus.rdata_last), 64'd1);
    step();
    bus.rdata_ready = 1'b0;
    check("nb_berr_sticky", 64'(burst_err), 64'd1);

    // Flush at level 5 with push and pop in the same cycle
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h7000 + 16'(i), 16'h8000 + 16'(i));
      step();
    end
    check("fl_level5", 64'(level), 64'd5);
    clr = 1'b1;
    bus.rdata_ready = 1'b1;
    drive(1'b1, 16'hFFFF, 16'hFFFF);
    step();
    clr = 1'b0;
    bus.rdata_ready = 1'b0;
    check("fl_level", 64'(level), 64'd0);
    check("fl_valid", 64'(bus.rdata_valid), 64'd0);
    check("fl_ovf", 64'(overflow), 64'd0);
    check("fl_berr", 64'(burst_err), 64'd0);
    drive(1'b0, 16'h0000, 16'h0000);
    step();
    check("fl_fsm_idle", 64'(burst_err), 64'd0);

    // Reset mid-burst
    drive(1'b1, 16'h0A0A, 16'h0B0B);
    step();
    reset_n = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000);
    step();
    check("mr_level", 64'(level), 64'd0);
    check("mr_valid", 64'(bus.rdata_valid), 64'd0);
    check("mr_berr", 64'(burst_err), 64'd0);
    reset_n = 1'b1;
    step();
    drive(1'b1, 16'h0C0C, 16'h0D0D);
    step();
    drive(1'b1, 16'h0E0E, 16'h0F0F);
    step();
    drive(1'b0, 16'h0000, 16'h0000);
    step();
    check("mr_berr2", 64'(burst_err), 64'd0);
    check("mr_level2", 64'(level), 64'd2);
    check("mr_head0", 64'(bus.rdata_dout), 64'h0C0C0D0D);
    check("mr_last0", 64'(bus.rdata_last), 64'd0);
    bus.rdata_ready = 1'b1;
    step();
    bus.rdata_ready = 1'b0;
    check("mr_head1", 64'(bus.rdata_dout), 64'h0E0E0F0F);
    check("mr_last1", 64'(bus.rdata_last), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
